// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: scroll feeder FSM encoding, blank pattern and the
// active-low hex segment table also used by the display top's decoder.
package seg7_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      SCROLL = 2'd2
   } feed_state_t;

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Entry n is hex digit n; bit0..6 = segments a..g, bit7 = dp, all active low.
   localparam logic [15:0][7:0] SEG_HEX_TABLE = {
      8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

endpackage

// File: rtl/seg7_hex_enc.sv
// Hex digit to active-low segment byte (dp off); only built when SEG7_FEED_BLANK_GAP_EN
// is defined, since the text-only feeder hands raw nibbles to the display.
`ifdef SEG7_FEED_BLANK_GAP_EN
module seg7_hex_enc
   import seg7_pkg::*;
(
   input  logic [3:0] hex,
   output logic [7:0] seg
);

   assign seg = SEG_HEX_TABLE[hex];

endmodule
`endif

// File: rtl/seg7_scroll_feeder.sv
// Message store + 8-digit scrolling window feeding the 7-seg display top.
// Optional SEG7_FEED_BLANK_GAP_EN inserts 8 blank slots per period and switches to raw segments.
module seg7_scroll_feeder
   import seg7_pkg::*;
#(
   parameter int unsigned MSG_DEPTH  = 32,
   parameter int unsigned SCROLL_DIV = 25_000_000,
   parameter int unsigned CNT_W      = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1
) (
   input  logic        CLK100MHZ,
   input  logic        CPU_RESET,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [3:0]  wr_data,
   input  logic        wr_last,
   input  logic        i_pause,
   input  logic        i_clear,
   output logic [63:0] o_data,
   output logic        o_disp_mode,
   output logic        o_busy,
   output logic        o_wrap
);

   localparam int unsigned AW = $clog2(MSG_DEPTH);
   localparam int unsigned IW = $clog2(MSG_DEPTH + 16);
`ifdef SEG7_FEED_BLANK_GAP_EN
   localparam int unsigned GAP = 8;
`else
   localparam int unsigned GAP = 0;
`endif

   feed_state_t      state_q, state_d;
   logic [IW-1:0]    wptr_q, wptr_d;
   logic [IW-1:0]    len_q, len_d;
   logic [IW-1:0]    head_q, head_d;
   logic [CNT_W-1:0] tick_q, tick_d;
   logic             wrap_q, wrap_d;
   logic [63:0]      data_d;
   logic             mode_d, busy_d, wrap_out_d;

   logic             can_accept, beat, last_beat;
   logic [IW-1:0]    period;
   logic [3:0]       msg [MSG_DEPTH];
   logic [IW-1:0]    slot_idx [8];
   logic [3:0]       slot_dig [8];
   logic [63:0]      win_data;
   logic             win_mode;

   assign period     = len_q + IW'(GAP);
   assign can_accept = (state_q == IDLE || state_q == LOAD) && !i_clear;
   assign wr_ready   = can_accept && !CPU_RESET;
   assign beat       = wr_valid && can_accept;
   assign last_beat  = beat && (wr_last || wptr_q == IW'(MSG_DEPTH - 1));

   // Message store: written one digit per beat, read at eight window positions.
   always_ff @(posedge CLK100MHZ) begin
      if (beat) msg[AW'(wptr_q)] <= wr_data;
   end

   // Window slot i sits at (head + i) mod period; repeated subtraction covers len < 8.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         slot_idx[i] = head_q + IW'(i);
         for (int j = 0; j < 8; j++) begin
            if (slot_idx[i] >= period) slot_idx[i] = slot_idx[i] - period;
         end
         slot_dig[i] = msg[AW'(slot_idx[i])];
      end
   end

`ifdef SEG7_FEED_BLANK_GAP_EN
   logic [7:0] slot_seg [8];
   logic [7:0] slot_blank;

   for (genvar g = 0; g < 8; g++) begin : g_enc
      seg7_hex_enc u_enc (
         .hex (slot_dig[g]),
         .seg (slot_seg[g])
      );
      assign slot_blank[g] = (slot_idx[g] >= len_q);
   end
`endif

   // Text nibbles by default; any blank slot switches the whole window to raw segments.
   always_comb begin
      win_data = '0;
      win_mode = 1'b0;
      for (int i = 0; i < 8; i++) win_data[31-4*i -: 4] = slot_dig[i];
`ifdef SEG7_FEED_BLANK_GAP_EN
      if (|slot_blank) begin
         win_mode = 1'b1;
         for (int i = 0; i < 8; i++)
            win_data[63-8*i -: 8] = slot_blank[i] ? SEG_BLANK : slot_seg[i];
      end
`endif
   end

   // Next state, pointers, tick/head stepping and registered output values.
   always_comb begin
      state_d = state_q;
      wptr_d  = wptr_q;
      len_d   = len_q;
      head_d  = head_q;
      tick_d  = tick_q;
      wrap_d  = 1'b0;
      data_d  = '0;
      mode_d  = 1'b0;

      case (state_q)
         IDLE, LOAD: begin
            if (beat) begin
               wptr_d  = wptr_q + IW'(1);
               state_d = LOAD;
               if (last_beat) begin
                  len_d   = wptr_q + IW'(1);
                  head_d  = '0;
                  tick_d  = '0;
                  state_d = SCROLL;
               end
            end
         end
         SCROLL: begin
            data_d = win_data;
            mode_d = win_mode;
            if (!i_pause) begin
               if (tick_q == CNT_W'(SCROLL_DIV - 1)) begin
                  tick_d = '0;
                  if (head_q == period - IW'(1)) begin
                     head_d = '0;
                     wrap_d = 1'b1;
                  end else begin
                     head_d = head_q + IW'(1);
                  end
               end else begin
                  tick_d = tick_q + CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (i_clear) begin
         state_d = IDLE;
         wptr_d  = '0;
         len_d   = '0;
         head_d  = '0;
         tick_d  = '0;
         wrap_d  = 1'b0;
         data_d  = '0;
         mode_d  = 1'b0;
      end

      busy_d     = (state_d == SCROLL);
      // Wrap pulse lines up with the first o_data word showing head 0.
      wrap_out_d = wrap_q && !i_clear;
   end

   always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
      if (CPU_RESET) begin
         state_q     <= IDLE;
         wptr_q      <= '0;
         len_q       <= '0;
         head_q      <= '0;
         tick_q      <= '0;
         wrap_q      <= 1'b0;
         o_data      <= '0;
         o_disp_mode <= 1'b0;
         o_busy      <= 1'b0;
         o_wrap      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wptr_q      <= wptr_d;
         len_q       <= len_d;
         head_q      <= head_d;
         tick_q      <= tick_d;
         wrap_q      <= wrap_d;
         o_data      <= data_d;
         o_disp_mode <= mode_d;
         o_busy      <= busy_d;
         o_wrap      <= wrap_out_d;
      end
   end

endmodule
